// File: rtl/fir_pkg.sv
// Shared definitions for the 8-parallel FIR output path.
`default_nettype none
package fir_pkg;
  localparam int FIR_DW    = 16;
  localparam int FIR_LANES = 8;

  typedef logic signed [FIR_DW-1:0]       fir_sample_t;
  typedef logic [$clog2(FIR_LANES)-1:0]   fir_lane_idx_t;

  // Occupancy of the two-entry block buffer
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fir_cnt_e;
endpackage
`default_nettype wire

// File: rtl/fir_block_buf.sv
// Two-entry ping-pong block store; read port picks one lane of the oldest block.
`default_nettype none
module fir_block_buf
  import fir_pkg::*;
#(
  parameter int DW    = FIR_DW,
  parameter int LANES = FIR_LANES,
  localparam int LW   = $clog2(LANES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en_i,
  input  logic [LANES*DW-1:0] wr_data_i,
  input  logic                rd_adv_i,
  input  logic [LW-1:0]       lane_i,
  output logic [DW-1:0]       rd_data_o
);

  logic [LANES*DW-1:0] mem_q [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_en_i  ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = rd_adv_i ? ~rd_ptr_q : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only visible once cnt says so
  always_ff @(posedge clk) begin
    if (!rst && wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q][lane_i*DW +: DW];

endmodule
`default_nettype wire

// File: rtl/fir_lane_serializer.sv
// Serialises 8-lane FIR result blocks into a 1-sample/clk stream, lane0 first.
`default_nettype none
module fir_lane_serializer
  import fir_pkg::*;
#(
  parameter int DW    = FIR_DW,
  parameter int LANES = FIR_LANES,
  localparam int LW   = $clog2(LANES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [LANES*DW-1:0] in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DW-1:0]       out_data_o,
  output logic                out_first_o,
  output logic                out_last_o
);

  fir_cnt_e        cnt_q, cnt_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic            w_accept;
  logic            w_pop;
  logic            w_lane_last;
  logic            w_retire;
  logic [DW-1:0]   w_rd_sample;

  // in_ready depends on registered state only, never on out_ready
  assign in_ready_o  = (cnt_q != FULL);
  assign out_valid_o = (cnt_q != EMPTY);
  assign w_accept    = in_valid_i & in_ready_o;
  assign w_lane_last = (lane_q == LW'(LANES - 1));
  assign w_pop       = out_valid_o & out_ready_i;
  assign w_retire    = w_pop & w_lane_last;

  fir_block_buf #(
    .DW    (DW),
    .LANES (LANES)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (w_accept),
    .wr_data_i (in_data_i),
    .rd_adv_i  (w_retire),
    .lane_i    (lane_q),
    .rd_data_o (w_rd_sample)
  );

  always_comb begin
    cnt_d  = cnt_q;
    lane_d = lane_q;
    if (w_pop) begin
      lane_d = w_lane_last ? '0 : lane_q + 1'b1;
    end
    case ({w_accept, w_retire})
      2'b10:   cnt_d = (cnt_q == EMPTY) ? ONE : FULL;
      2'b01:   cnt_d = (cnt_q == FULL)  ? ONE : EMPTY;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= EMPTY;
      lane_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      lane_q <= lane_d;
    end
  end

  assign out_data_o  = out_valid_o ? w_rd_sample : '0;
  assign out_first_o = out_valid_o & (lane_q == '0);
  assign out_last_o  = out_valid_o & w_lane_last;

endmodule
`default_nettype wire

// File: tb/tb_fir_lane_serializer.sv
// Directed and random-stall bench for fir_lane_serializer.
`default_nettype none
module tb_fir_lane_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_data;
  logic         out_first;
  logic         out_last;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fir_lane_serializer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_first_o (out_first),
    .out_last_o  (out_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_block(input logic [15:0] base);
    logic [127:0] b;
    for (int k = 0; k < 8; k++) b[k*16 +: 16] = base + 16'(k);
    return b;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_data = {8{16'h7FFF}};
    for (int c = 0; c < 2; c++) begin
      tick();
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid c%0d got %b want 0", c, out_valid); else n_pass++;
      n_total++; if (out_data !== 16'h0) $display("FAIL reset_data c%0d got %h want 0000", c, out_data); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL reset_ready c%0d got %b want 1", c, in_ready); else n_pass++;
      n_total++; if ({out_first, out_last} !== 2'b00) $display("FAIL reset_flags c%0d got %b want 00", c, {out_first, out_last}); else n_pass++;
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL post_reset_empty got %b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL post_reset_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_single_block();
    out_ready = 1'b1; in_valid = 1'b1; in_data = mk_block(16'h0001);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_total++; if (out_valid !== 1'b1) $display("FAIL single_valid lane%0d got %b want 1", k, out_valid); else n_pass++;
      n_total++; if (out_data !== 16'(k + 1)) $display("FAIL single_data lane%0d got %h want %h", k, out_data, 16'(k + 1)); else n_pass++;
      n_total++; if (out_first !== (k == 0)) $display("FAIL single_first lane%0d got %b want %b", k, out_first, (k == 0)); else n_pass++;
      n_total++; if (out_last !== (k == 7)) $display("FAIL single_last lane%0d got %b want %b", k, out_last, (k == 7)); else n_pass++;
      tick();
    end
    n_total++; if (out_valid !== 1'b0) $display("FAIL single_drain got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_data !== 16'h0) $display("FAIL single_drain_data got %h want 0000", out_data); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] bases [3];
    int blk = 0, idx = 0, low_run = 0, max_low = 0;
    logic [15:0] exp_d;
    bases[0] = 16'h8000; bases[1] = 16'h1234; bases[2] = 16'hFFFF;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && idx < 24; cyc++) begin
      in_valid = (blk < 3);
      if (blk < 3) in_data = mk_block(bases[blk]);
      if (out_valid || idx > 0) begin
        n_total++; if (out_valid !== 1'b1) $display("FAIL stream_bubble idx%0d got %b want 1", idx, out_valid); else n_pass++;
        exp_d = bases[idx / 8] + 16'(idx % 8);
        n_total++; if (out_data !== exp_d) $display("FAIL stream_data idx%0d got %h want %h", idx, out_data, exp_d); else n_pass++;
        n_total++; if ({out_first, out_last} !== {idx % 8 == 0, idx % 8 == 7}) $display("FAIL stream_flags idx%0d got %b want %b", idx, {out_first, out_last}, {idx % 8 == 0, idx % 8 == 7}); else n_pass++;
        idx++;
      end
      if (!in_ready) low_run++; else low_run = 0;
      if (low_run > max_low) max_low = low_run;
      if (in_valid && in_ready) blk++;
      tick();
    end
    in_valid = 1'b0;
    n_total++; if (idx !== 24) $display("FAIL stream_count got %0d want 24", idx); else n_pass++;
    n_total++; if (max_low > 7) $display("FAIL stream_ready_low got %0d clk want <=7", max_low); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL stream_drain got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic [15:0] exp_d;
    out_ready = 1'b0; in_valid = 1'b1; in_data = mk_block(16'h0100);
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (in_valid && in_ready) acc++;
      tick();
      if (acc == 1) in_data = mk_block(16'h0200);
      if (acc == 2) in_data = mk_block(16'h0300);
    end
    n_total++; if (acc !== 2) $display("FAIL bp_accepts got %0d want 2", acc); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full got %b want 0", in_ready); else n_pass++;
    n_total++; if (out_data !== 16'h0100) $display("FAIL bp_frozen_data got %h want 0100", out_data); else n_pass++;
    n_total++; if ({out_valid, out_first, out_last} !== 3'b110) $display("FAIL bp_frozen_flags got %b want 110", {out_valid, out_first, out_last}); else n_pass++;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_d = ((i < 8) ? 16'h0100 : 16'h0200) + 16'(i % 8);
      n_total++; if (out_data !== exp_d) $display("FAIL bp_data i%0d got %h want %h", i, out_data, exp_d); else n_pass++;
      n_total++; if (in_ready !== (i >= 8)) $display("FAIL bp_ready i%0d got %b want %b", i, in_ready, (i >= 8)); else n_pass++;
      tick();
    end
    n_total++; if (out_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_block();
    out_ready = 1'b1; in_valid = 1'b1; in_data = mk_block(16'hA000);
    tick();
    in_data = mk_block(16'hA100);
    for (int k = 0; k < 4; k++) begin
      n_total++; if (out_data !== 16'hA000 + 16'(k)) $display("FAIL mid_a_data lane%0d got %h want %h", k, out_data, 16'hA000 + 16'(k)); else n_pass++;
      tick();
      in_valid = 1'b0;
    end
    rst = 1'b1; in_valid = 1'b1;
    tick();
    n_total++; if ({out_valid, out_data} !== 17'h0) $display("FAIL mid_rst_out got %b/%h want 0/0000", out_valid, out_data); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL mid_rst_ready got %b want 1", in_ready); else n_pass++;
    rst = 1'b0; in_valid = 1'b1; in_data = mk_block(16'hB000);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_total++; if (out_data !== 16'hB000 + 16'(k)) $display("FAIL mid_b_data lane%0d got %h want %h", k, out_data, 16'hB000 + 16'(k)); else n_pass++;
      n_total++; if (out_first !== (k == 0)) $display("FAIL mid_b_first lane%0d got %b want %b", k, out_first, (k == 0)); else n_pass++;
      tick();
    end
    n_total++; if (out_valid !== 1'b0) $display("FAIL mid_no_stale got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_random_stall();
    localparam int NB = 300;
    logic [127:0] rb [NB];
    logic [127:0] tmp;
    logic [15:0]  exp_d;
    int wr = 0, rd = 0, bad = 0;
    for (int b = 0; b < NB; b++) rb[b] = {$urandom, $urandom, $urandom, $urandom};
    for (int cyc = 0; cyc < 20000 && rd < NB * 8; cyc++) begin
      in_valid  = (wr < NB) && ($urandom_range(3) != 0);
      in_data   = (wr < NB) ? rb[wr] : '0;
      out_ready = ($urandom_range(2) != 0);
      if (out_valid && out_ready) begin
        tmp   = rb[rd / 8];
        exp_d = tmp[(rd % 8) * 16 +: 16];
        n_total++;
        if (out_data !== exp_d || out_first !== (rd % 8 == 0) || out_last !== (rd % 8 == 7)) begin
          if (bad < 10) $display("FAIL rand_sample #%0d got %h/%b%b want %h/%b%b", rd, out_data, out_first, out_last, exp_d, (rd % 8 == 0), (rd % 8 == 7));
          bad++;
        end else n_pass++;
        rd++;
      end
      if (in_valid && in_ready) wr++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_total++; if (rd !== NB * 8) $display("FAIL rand_timeout got %0d samples want %0d", rd, NB * 8); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_single_block();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_block();
    test_random_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
